// File: rtl/rng_pool.sv
// rtl/rng_pool.sv - 128-bit LFSR random word pool with output FIFO and reseed port.
// Define RNG_POOL_HEALTH_EN to build the repetition health test that drives alarm.
module rng_pool #(
  parameter int          OUT_W = 32,
  parameter int          DEPTH = 4,
  parameter logic [127:0] SEED = 128'hA5A5A5A5_3C3C3C3C_96969696_F0F0F0F0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       seed_valid,
  input  logic [127:0]               seed_data,
  output logic                       seed_ready,
  output logic                       rng_valid,
  input  logic                       rng_ready,
  output logic [OUT_W-1:0]           rng_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       alarm,
  input  logic                       alarm_clr
);
  localparam int CW = $clog2(OUT_W);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {ST_RUN, ST_SEED} state_t;

  state_t            state_q, state_d;
  logic              seed_ready_q, seed_ready_d;
  logic [127:0]      lfsr_q, lfsr_d, lfsr_step, lfsr_mix;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [OUT_W-1:0]  mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              alarm_q, alarm_d;
  logic              handshake, step, harvest, pop, full, rep, push, drop;
  logic [OUT_W-1:0]  cand;
`ifdef RNG_POOL_HEALTH_EN
  logic [OUT_W-1:0]  ref_q, ref_d;
`endif

  always_comb begin
    lfsr_step = {lfsr_q[126:0], lfsr_q[127] ^ lfsr_q[125] ^ lfsr_q[100] ^
                                lfsr_q[98] ^ lfsr_q[67] ^ lfsr_q[31]};
    lfsr_mix  = lfsr_q ^ seed_data;
    handshake = seed_valid && seed_ready_q;
    // A reseed in the same cycle overrides stepping, so a word due now is lost.
    step      = enable && (state_q == ST_RUN) && !handshake;
    harvest   = step && (cnt_q == CW'(OUT_W-1));
    cand      = lfsr_step[OUT_W-1:0];
    pop       = (level_q != '0) && rng_ready;
    full      = (level_q == LW'(DEPTH));
`ifdef RNG_POOL_HEALTH_EN
    rep       = harvest && (cand == ref_q);
    ref_d     = ref_q;
    if (handshake)    ref_d = '0;
    else if (harvest) ref_d = cand;
`else
    rep       = 1'b0;
`endif
    push      = harvest && !rep && (!full || pop);
    drop      = harvest && !rep && full && !pop;

    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    if (handshake) begin
      lfsr_d = (lfsr_mix == '0) ? SEED : lfsr_mix;
      cnt_d  = '0;
    end else if (step) begin
      lfsr_d = lfsr_step;
      cnt_d  = harvest ? '0 : cnt_q + CW'(1);
    end

    state_d      = handshake ? ST_SEED : ST_RUN;
    seed_ready_d = (state_d == ST_RUN);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = cand;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // Clear beats any same-cycle set.
    overflow_d = alarm_clr ? 1'b0 : (overflow_q | drop);
    alarm_d    = alarm_clr ? 1'b0 : (alarm_q | rep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      seed_ready_q <= 1'b0;
      lfsr_q       <= SEED;
      cnt_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      alarm_q      <= 1'b0;
`ifdef RNG_POOL_HEALTH_EN
      ref_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seed_ready_q <= seed_ready_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      alarm_q      <= alarm_d;
`ifdef RNG_POOL_HEALTH_EN
      ref_q        <= ref_d;
`endif
    end
  end

  assign seed_ready = seed_ready_q;
  assign rng_valid  = (level_q != '0);
  assign rng_data   = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = overflow_q;
`ifdef RNG_POOL_HEALTH_EN
  assign alarm      = alarm_q;
`else
  assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_rng_pool.sv
// tb/tb_rng_pool.sv - directed self-checking bench for rng_pool (default parameters).
module tb_rng_pool;
  localparam logic [127:0] SEED_V = 128'hA5A5A5A5_3C3C3C3C_96969696_F0F0F0F0;
  localparam logic [127:0] XSEED  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         seed_valid = 1'b0;
  logic [127:0] seed_data = '0;
  logic         seed_ready;
  logic         rng_valid;
  logic         rng_ready = 1'b0;
  logic [31:0]  rng_data;
  logic [2:0]   level;
  logic         overflow;
  logic         alarm;
  logic         alarm_clr = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic [31:0]  w [1:5];
  logic [127:0] lf;

  rng_pool dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(seed_ready), .rng_valid(rng_valid),
    .rng_ready(rng_ready), .rng_data(rng_data), .level(level),
    .overflow(overflow), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] adv(input logic [127:0] l, input int n);
    logic [127:0] r;
    r = l;
    for (int i = 0; i < n; i++)
      r = {r[126:0], r[127] ^ r[125] ^ r[100] ^ r[98] ^ r[67] ^ r[31]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; seed_valid = 1'b0; rng_ready = 1'b0; alarm_clr = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", rng_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_seed_ready", seed_ready, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    lf = SEED_V;
    for (int k = 1; k <= 5; k++) begin
      lf = adv(lf, 32);
      w[k] = lf[31:0];
    end

    // First word latency, then fill past full with no consumer.
    do_reset();
    chk("rst_data", rng_data, 0);
    chk("rst_alarm", alarm, 0);
    enable = 1'b1;
    repeat (31) tick();
    chk("seed_ready_up", seed_ready, 1);
    chk("valid_before_w1", rng_valid, 0);
    tick();
    chk("valid_w1", rng_valid, 1);
    chk("data_w1", rng_data, w[1]);
    chk("level_w1", level, 1);
    repeat (128) tick();
    enable = 1'b0;
    chk("full_level", level, 4);
    chk("full_overflow", overflow, 1);
    chk("full_head", rng_data, w[1]);
    chk("alarm_off", alarm, 0);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_level", level, 4);

    // Pop coinciding with the fifth harvest at full: no overflow.
    do_reset();
    enable = 1'b1;
    repeat (159) tick();
    rng_ready = 1'b1;
    tick();
    rng_ready = 1'b0;
    enable = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_overflow", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp_word%0d", k), rng_data, w[k]);
      rng_ready = 1'b1;
      tick();
      rng_ready = 1'b0;
    end
    chk("drained_valid", rng_valid, 0);
    chk("drained_level", level, 0);
    rng_ready = 1'b1;
    tick();
    rng_ready = 1'b0;
    chk("pop_empty_level", level, 0);

    // Reseed with SEED on the reset-state LFSR: zero XOR recovers SEED.
    do_reset();
    tick();
    seed_valid = 1'b1; seed_data = SEED_V; enable = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("seed_state_ready", seed_ready, 0);
    tick();
    chk("seed_back_ready", seed_ready, 1);
    chk("seed_level", level, 0);
    repeat (31) tick();
    chk("zs_valid_early", rng_valid, 0);
    tick();
    chk("zs_valid", rng_valid, 1);
    chk("zs_data", rng_data, w[1]);

    // Mid-word reseed with a non-zero value restarts the bit counter.
    do_reset();
    enable = 1'b1;
    repeat (10) tick();
    seed_valid = 1'b1; seed_data = XSEED;
    tick();
    seed_valid = 1'b0;
    tick();
    lf = adv(adv(SEED_V, 10) ^ XSEED, 32);
    repeat (31) tick();
    chk("xs_valid_early", rng_valid, 0);
    tick();
    chk("xs_valid", rng_valid, 1);
    chk("xs_data", rng_data, lf[31:0]);

    // Enable gap at counter 17.
    do_reset();
    enable = 1'b1;
    repeat (17) tick();
    enable = 1'b0;
    repeat (10) tick();
    enable = 1'b1;
    repeat (14) tick();
    chk("gap_valid_early", rng_valid, 0);
    tick();
    enable = 1'b0;
    chk("gap_valid", rng_valid, 1);
    chk("gap_data", rng_data, w[1]);
    chk("gap_alarm", alarm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
